// File: rtl/io_bus_hub_if.sv
// CPU-side bus bundle for io_bus_hub: device capture inputs, the word-addressed CPU port,
// and the hub outputs.
// cpu_rd/cpu_wr are single-cycle strobes with no backpressure. Each cycle with a strobe high is
// one request, sampled at the rising clk edge. Read data appears on cpu_rdata one cycle later
// and holds until the next read.
interface io_bus_hub_if #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 2,
  parameter int ADDR_W = 8
);
  logic [N_CH-1:0]        is_ready;
  logic [N_CH*DATA_W-1:0] data_input;
  logic [ADDR_W-1:0]      cpu_addr;
  logic                   cpu_rd;
  logic                   cpu_wr;
  logic [DATA_W-1:0]      cpu_wdata;
  logic [DATA_W-1:0]      cpu_rdata;
  logic [DATA_W-1:0]      data_output;
  logic                   out_valid;
  logic [N_CH-1:0]        overflow;
  logic                   irq;

  modport master (
    output is_ready, data_input, cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    input  cpu_rdata, data_output, out_valid, overflow, irq
  );

  modport slave (
    input  is_ready, data_input, cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    output cpu_rdata, data_output, out_valid, overflow, irq
  );
endinterface

// File: rtl/io_bus_hub.sv
// Parametrised I/O bus hub: edge-captures device words into per-channel FIFOs and exposes
// status, control, channel data and an output register on a memory-mapped CPU port.
module io_bus_hub #(
  parameter int         DATA_W     = 32,
  parameter int         N_CH       = 2,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] EDGE_MASK  = 8'h01,
  parameter int         ADDR_W     = 8
) (
  input logic         clk,
  input logic         rst,
  io_bus_hub_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OUT    = ADDR_W'(2);

  logic [N_CH-1:0]   hist_q, hist_d;
  logic [DATA_W-1:0] mem_q [N_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [N_CH];
  logic [PTR_W-1:0]  wr_ptr_d [N_CH];
  logic [PTR_W-1:0]  rd_ptr_q [N_CH];
  logic [PTR_W-1:0]  rd_ptr_d [N_CH];
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]   ovf_q, ovf_d;
  logic [7:0]        irq_en_q, irq_en_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              oval_q, oval_d;
  logic              irq_q, irq_d;

  logic [N_CH-1:0]   not_empty, full, push_req, push_ok, pop, ovf_set, w1c;
  logic              rd_only;
  logic [DATA_W-1:0] status, rd_val;

  // A simultaneous write wins the cycle, so only a lone read may pop.
  assign rd_only = bus.cpu_rd & ~bus.cpu_wr;

  always_comb begin
    not_empty = '0;
    full      = '0;
    push_req  = '0;
    push_ok   = '0;
    pop       = '0;
    ovf_set   = '0;
    for (int c = 0; c < N_CH; c++) begin
      not_empty[c] = (cnt_q[c] != '0);
      full[c]      = (cnt_q[c] == CNT_W'(FIFO_DEPTH));
      push_req[c]  = bus.is_ready[c] & ~hist_q[c] & EDGE_MASK[c];
      pop[c]       = rd_only & (bus.cpu_addr == ADDR_W'(16 + c)) & not_empty[c];
      // A same-cycle pop frees the slot, so a full channel only overflows without one.
      push_ok[c]   = push_req[c] & (~full[c] | pop[c]);
      ovf_set[c]   = push_req[c] & full[c] & ~pop[c];
    end
  end

  always_comb begin
    status = '0;
    for (int c = 0; c < N_CH; c++) begin
      status[c]      = not_empty[c];
      status[8 + c]  = ovf_q[c];
      status[16 + c] = bus.is_ready[c];
    end
  end

  always_comb begin
    rd_val = '0;
    if (bus.cpu_addr == A_STATUS) begin
      rd_val = status;
    end else if (bus.cpu_addr == A_CTRL) begin
      rd_val = DATA_W'(irq_en_q);
    end else if (bus.cpu_addr == A_OUT) begin
      rd_val = dout_q;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (bus.cpu_addr == ADDR_W'(16 + c) && not_empty[c]) begin
        rd_val = mem_q[c][rd_ptr_q[c]];
      end
    end
  end

  always_comb begin
    hist_d   = bus.is_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < N_CH; c++) begin
      if (push_ok[c]) begin
        mem_d[c][wr_ptr_q[c]] = bus.data_input[c*DATA_W +: DATA_W];
        wr_ptr_d[c]           = wr_ptr_q[c] + PTR_W'(1);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
      end
      case ({push_ok[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CNT_W'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  always_comb begin
    w1c      = '0;
    irq_en_d = irq_en_q;
    dout_d   = dout_q;
    oval_d   = 1'b0;
    if (bus.cpu_wr) begin
      if (bus.cpu_addr == A_STATUS) w1c = bus.cpu_wdata[8 +: N_CH];
      if (bus.cpu_addr == A_CTRL) irq_en_d = bus.cpu_wdata[7:0];
      if (bus.cpu_addr == A_OUT) begin
        dout_d = bus.cpu_wdata;
        oval_d = 1'b1;
      end
    end
    // Set beats clear when a new overflow lands on the clearing write.
    ovf_d = (ovf_q & ~w1c) | ovf_set;
    if (bus.cpu_rd && bus.cpu_wr) begin
      rdata_d = '0;
    end else if (bus.cpu_rd) begin
      rdata_d = rd_val;
    end else begin
      rdata_d = rdata_q;
    end
    irq_d = |(not_empty & irq_en_q[N_CH-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '1;
      ovf_q    <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      dout_q   <= '0;
      oval_q   <= 1'b0;
      irq_q    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[c][i] <= '0;
      end
    end else begin
      hist_q   <= hist_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      dout_q   <= dout_d;
      oval_q   <= oval_d;
      irq_q    <= irq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.cpu_rdata   = rdata_q;
  assign bus.data_output = dout_q;
  assign bus.out_valid   = oval_q;
  assign bus.overflow    = ovf_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_io_bus_hub.sv
// Bench for io_bus_hub: directed sequences, a register vector table, then randomized traffic
// scored against a queue-based model of the hub.
module tb_io_bus_hub;
  localparam int         DATA_W     = 32;
  localparam int         N_CH       = 2;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] EDGE_MASK  = 8'h01;
  localparam int         ADDR_W     = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  io_bus_hub_if #(.DATA_W(DATA_W), .N_CH(N_CH), .ADDR_W(ADDR_W)) bus ();

  io_bus_hub #(
    .DATA_W(DATA_W), .N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH),
    .EDGE_MASK(EDGE_MASK), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the visible registers.
  logic [DATA_W-1:0] exp_q [N_CH][$];
  logic [N_CH-1:0]   m_ovf, m_hist;
  logic [7:0]        m_en;
  logic [DATA_W-1:0] m_rdata, m_dout;
  logic              m_oval, m_irq;

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) exp_q[c].delete();
    m_ovf = '0; m_hist = '1; m_en = '0;
    m_rdata = '0; m_dout = '0; m_oval = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    if (a == 0) begin
      for (int c = 0; c < N_CH; c++) begin
        r[c]      = (exp_q[c].size() != 0);
        r[8 + c]  = m_ovf[c];
        r[16 + c] = bus.is_ready[c];
      end
    end else if (a == 1) begin
      r = DATA_W'(m_en);
    end else if (a == 2) begin
      r = m_dout;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (a == ADDR_W'(16 + c) && exp_q[c].size() != 0) r = exp_q[c][0];
    end
    return r;
  endfunction

  task automatic model_edge();
    logic [N_CH-1:0]   ne, setv;
    logic [DATA_W-1:0] rv, junk;
    ne = '0;
    for (int c = 0; c < N_CH; c++) ne[c] = (exp_q[c].size() != 0);
    rv    = model_read(bus.cpu_addr);
    m_irq = |(ne & m_en[N_CH-1:0]);
    if (bus.cpu_rd && bus.cpu_wr) m_rdata = '0;
    else if (bus.cpu_rd) m_rdata = rv;
    setv = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.cpu_rd && !bus.cpu_wr && bus.cpu_addr == ADDR_W'(16 + c) && ne[c])
        junk = exp_q[c].pop_front();
      if (bus.is_ready[c] && !m_hist[c] && EDGE_MASK[c]) begin
        if (exp_q[c].size() < FIFO_DEPTH) exp_q[c].push_back(bus.data_input[c*DATA_W +: DATA_W]);
        else setv[c] = 1'b1;
      end
    end
    m_oval = 1'b0;
    if (bus.cpu_wr) begin
      if (bus.cpu_addr == 0) m_ovf = m_ovf & ~bus.cpu_wdata[8 +: N_CH];
      if (bus.cpu_addr == 1) m_en = bus.cpu_wdata[7:0];
      if (bus.cpu_addr == 2) begin
        m_dout = bus.cpu_wdata;
        m_oval = 1'b1;
      end
    end
    m_ovf  = m_ovf | setv;
    m_hist = bus.is_ready;
  endtask

  // One clock: advance the model on the inputs presented, then sample 1ns after the edge.
  task automatic step();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    step();
    bus.cpu_rd = 1'b0;
    d = bus.cpu_rdata;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_wr    = 1'b1;
    step();
    bus.cpu_wr = 1'b0;
  endtask

  task automatic pulse(input int ch, input logic [DATA_W-1:0] d);
    bus.is_ready[ch] = 1'b1;
    bus.data_input[ch*DATA_W +: DATA_W] = d;
    step();
    bus.is_ready[ch] = 1'b0;
    step();
  endtask

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t              vecs [12];
  logic [DATA_W-1:0] rd;
  logic [ADDR_W-1:0] addr_pool [8];
  int                op;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.is_ready   = 2'b10;
    bus.data_input = '0;
    bus.cpu_addr   = '0;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_wdata  = '0;
    #1 rst = 1'b1;
    model_reset();
    #2;
    check("reset_rdata", bus.cpu_rdata, 0);
    check("reset_dout", bus.data_output, 0);
    check("reset_oval", DATA_W'(bus.out_valid), 0);
    check("reset_ovf", DATA_W'(bus.overflow), 0);
    check("reset_irq", DATA_W'(bus.irq), 0);
    #5 rst = 1'b0;

    // T1/T2: single capture on ch0 while ch1 is held high from reset.
    step();
    pulse(0, 32'h1);
    cpu_read(8'h00, rd);
    check("t1_status_one", rd, 32'h0002_0001);
    cpu_read(8'h10, rd);
    check("t1_data", rd, 32'h1);
    cpu_read(8'h00, rd);
    check("t2_status_after_pop", rd, 32'h0002_0000);
    bus.is_ready[1] = 1'b0;
    step();

    // T3: overflow on the fifth word, drain, then W1C.
    for (int i = 1; i <= 5; i++) pulse(0, DATA_W'(i));
    check("t3_ovf_set", DATA_W'(bus.overflow), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      cpu_read(8'h10, rd);
      check("t3_drain", rd, (i == 5) ? 32'h0 : DATA_W'(i));
    end
    cpu_read(8'h00, rd);
    check("t3_status_ovf", rd, 32'h0000_0100);
    cpu_write(8'h00, 32'h100);
    check("t3_ovf_clear", DATA_W'(bus.overflow), 0);

    // T4: full channel with push and pop in the same cycle.
    for (int i = 10; i <= 13; i++) pulse(0, DATA_W'(i));
    bus.is_ready[0] = 1'b1;
    bus.data_input[DATA_W-1:0] = 32'd14;
    bus.cpu_addr = 8'h10;
    bus.cpu_rd   = 1'b1;
    step();
    bus.cpu_rd = 1'b0;
    bus.is_ready[0] = 1'b0;
    check("t4_pop_oldest", bus.cpu_rdata, 32'd10);
    check("t4_no_ovf", DATA_W'(bus.overflow), 0);
    step();
    for (int i = 11; i <= 15; i++) begin
      cpu_read(8'h10, rd);
      check("t4_drain", rd, (i == 15) ? 32'h0 : DATA_W'(i));
    end

    // Register-level vectors.
    vecs[0]  = '{1'b0, 1'b1, 8'h01, 32'h3,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'h01, 32'h0,        32'h3};
    vecs[2]  = '{1'b0, 1'b1, 8'h02, 32'hA5A5,     32'h0};
    vecs[3]  = '{1'b1, 1'b0, 8'h02, 32'h0,        32'hA5A5};
    vecs[4]  = '{1'b1, 1'b1, 8'h02, 32'h11,       32'h0};
    vecs[5]  = '{1'b1, 1'b0, 8'h02, 32'h0,        32'h11};
    vecs[6]  = '{1'b0, 1'b1, 8'h05, 32'hDEAD,     32'h0};
    vecs[7]  = '{1'b1, 1'b0, 8'h05, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b0, 8'h12, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b1, 8'h01, 32'hFFFFFF00, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 8'h01, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h0};
    for (int i = 0; i < 12; i++) begin
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_wdata = vecs[i].wdata;
      bus.cpu_rd    = vecs[i].rd;
      bus.cpu_wr    = vecs[i].wr;
      step();
      bus.cpu_rd = 1'b0;
      bus.cpu_wr = 1'b0;
      if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), bus.cpu_rdata, vecs[i].exp_rdata);
    end

    // T5: OUT write produces a one-cycle strobe.
    check("t5_oval_idle", DATA_W'(bus.out_valid), 0);
    cpu_write(8'h02, 32'h37);
    check("t5_dout", bus.data_output, 32'h37);
    check("t5_oval_high", DATA_W'(bus.out_valid), 1);
    step();
    check("t5_oval_low", DATA_W'(bus.out_valid), 0);

    // T6: irq timing, then asynchronous reset with entries queued.
    cpu_write(8'h01, 32'h1);
    bus.is_ready[0] = 1'b1;
    bus.data_input[DATA_W-1:0] = 32'h55;
    step();
    bus.is_ready[0] = 1'b0;
    check("t6_irq_capture_edge", DATA_W'(bus.irq), 0);
    step();
    check("t6_irq_next", DATA_W'(bus.irq), 1);
    pulse(0, 32'h66);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_irq", DATA_W'(bus.irq), 0);
    check("t6_rst_dout", bus.data_output, 0);
    #19 rst = 1'b0;
    cpu_read(8'h00, rd);
    check("t6_status_zero", rd, 0);
    cpu_read(8'h10, rd);
    check("t6_fifo_cleared", rd, 0);
    cpu_read(8'h01, rd);
    check("t6_ctrl_cleared", rd, 0);

    // Randomized traffic against the model.
    addr_pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h10, 8'h11, 8'h12};
    for (int n = 0; n < 400; n++) begin
      bus.is_ready = N_CH'($urandom_range(0, 3));
      for (int c = 0; c < N_CH; c++) bus.data_input[c*DATA_W +: DATA_W] = $urandom;
      op = $urandom_range(0, 9);
      bus.cpu_rd    = (op < 5);
      bus.cpu_wr    = (op >= 4 && op < 7);
      bus.cpu_addr  = addr_pool[$urandom_range(0, 7)];
      bus.cpu_wdata = $urandom;
      step();
      check("rnd_rdata", bus.cpu_rdata, m_rdata);
      check("rnd_irq", DATA_W'(bus.irq), DATA_W'(m_irq));
      check("rnd_ovf", DATA_W'(bus.overflow), DATA_W'(m_ovf));
      check("rnd_oval", DATA_W'(bus.out_valid), DATA_W'(m_oval));
      check("rnd_dout", bus.data_output, m_dout);
    end
    bus.is_ready = '0;
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
